// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial line plus received-word valid/ready stream of the configurable UART receiver
//   rxd        serial line into the receiver, idle high
//   tick       oversample strobe out of the receiver
//   data_out   received word, DATA_BITS wide
//   rx_valid   word available; rx_ready from the consumer accepts it
//   parity_err, frame_err, overrun  status of the held word
// master: the receiver side; slave: the pad/consumer side.
interface uart_rx_cfg_if #(parameter int DATA_BITS = 8);
  logic                 rxd;
  logic                 tick;
  logic [DATA_BITS-1:0] data_out;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  modport master (input rxd, rx_ready, output tick, data_out, rx_valid, parity_err, frame_err, overrun);
  modport slave (output rxd, rx_ready, input tick, data_out, rx_valid, parity_err, frame_err, overrun);
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with oversample tick generator, parity/stop checking and valid/ready output
//   clk    system clock, rising edge
//   reset  synchronous, active-high; aborts any frame in flight
//   rx     uart_rx_cfg_if.master: rxd in, rx_ready in, tick/data_out/rx_valid/parity_err/frame_err/overrun out
module uart_rx_cfg #(
  parameter int DIVISOR    = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input logic               clk,
  input logic               reset,
  uart_rx_cfg_if.master     rx
);
  localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVISOR - 1);
  localparam logic [SW-1:0] SC_HALF  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
  state_t               r_state, w_next;
  logic [1:0]           r_sync;
  logic [DW-1:0]        r_div;
  logic [SW-1:0]        r_sc;
  logic [BW-1:0]        r_bit;
  logic                 r_stop;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr, r_ferr, r_commit;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_perr_o, r_ferr_o, r_ovr;
  logic                 w_rxs, w_tick, w_half, w_end, w_last_stop;
  assign w_rxs       = r_sync[1];
  assign w_tick      = r_div == DIV_LAST;
  assign w_half      = r_sc == SC_HALF;
  assign w_end       = r_sc == SC_LAST;
  assign w_last_stop = (STOP_BITS == 1) || r_stop;
  always_comb begin
    w_next = r_state;
    if (w_tick)
      case (r_state)
        S_IDLE:   w_next = w_rxs ? S_IDLE : S_START;
        S_START:  if (w_half) w_next = w_rxs ? S_IDLE : S_DATA;
        S_DATA:   if (w_end && r_bit == BIT_LAST) w_next = (PARITY != 0) ? S_PARITY : S_STOP;
        S_PARITY: if (w_end) w_next = S_STOP;
        S_STOP:   if (w_end && w_last_stop) w_next = w_rxs ? S_IDLE : S_BREAK;
        default:  w_next = w_rxs ? S_IDLE : S_BREAK;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync   <= 2'b11;
      r_div    <= '0;
      r_state  <= S_IDLE;
      r_sc     <= '0;
      r_bit    <= '0;
      r_stop   <= 1'b0;
      r_shift  <= '0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_commit <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_o <= 1'b0;
      r_ferr_o <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], rx.rxd};
      r_div    <= w_tick ? '0 : r_div + 1'b1;
      r_state  <= w_next;
      // commit lands one cycle after the final stop-bit sample, once frame flags are settled
      r_commit <= w_tick && r_state == S_STOP && w_end && w_last_stop;
      if (w_tick) begin
        r_sc <= (w_next != r_state || w_end) ? '0 : r_sc + 1'b1;
        if (r_state == S_START) begin
          r_bit  <= '0;
          r_stop <= 1'b0;
          r_perr <= 1'b0;
          r_ferr <= 1'b0;
        end
        if (r_state == S_DATA && w_end) begin
          r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
          r_bit   <= r_bit + 1'b1;
        end
        // odd parity wants total XOR of 1, even wants 0
        if (r_state == S_PARITY && w_end) r_perr <= (^r_shift ^ w_rxs) != (PARITY == 1);
        if (r_state == S_STOP && w_end) begin
          r_stop <= ~r_stop;
          if (!w_rxs) r_ferr <= 1'b1;
        end
      end
      if (r_commit && (!r_valid || rx.rx_ready)) begin
        r_data   <= r_shift;
        r_perr_o <= r_perr;
        r_ferr_o <= r_ferr;
        r_valid  <= 1'b1;
        r_ovr    <= 1'b0;
      end else if (r_commit) begin
        r_ovr <= 1'b1;
      end else if (r_valid && rx.rx_ready) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end
  assign rx.tick       = w_tick;
  assign rx.data_out   = r_data;
  assign rx.rx_valid   = r_valid;
  assign rx.parity_err = r_perr_o;
  assign rx.frame_err  = r_ferr_o;
  assign rx.overrun    = r_ovr;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed checks of uart_rx_cfg in 8N1, 8E1 and 7N2 configurations
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic r8 = 1'b1, rp = 1'b1, r7 = 1'b1;
  logic rdy8 = 1'b1, rdyp = 1'b1, rdy7 = 1'b1;
  int pass_cnt = 0, total_cnt = 0;
  int nr8 = 0, nrp = 0, nr7 = 0, hi8 = 0;
  logic pv8 = 1'b0, pvp = 1'b0, pv7 = 1'b0;
  always #5 clk = ~clk;
  uart_rx_cfg_if #(.DATA_BITS(8)) b8();
  uart_rx_cfg_if #(.DATA_BITS(8)) bp();
  uart_rx_cfg_if #(.DATA_BITS(7)) b7();
  assign b8.rxd = r8;
  assign bp.rxd = rp;
  assign b7.rxd = r7;
  assign b8.rx_ready = rdy8;
  assign bp.rx_ready = rdyp;
  assign b7.rx_ready = rdy7;
  uart_rx_cfg #(.DIVISOR(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u8 (.clk(clk), .reset(reset), .rx(b8.master));
  uart_rx_cfg #(.DIVISOR(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    up (.clk(clk), .reset(reset), .rx(bp.master));
  uart_rx_cfg #(.DIVISOR(4), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
    u7 (.clk(clk), .reset(reset), .rx(b7.master));
  always @(posedge clk) begin
    pv8 <= b8.rx_valid;
    pvp <= bp.rx_valid;
    pv7 <= b7.rx_valid;
    if (b8.rx_valid && !pv8) nr8 <= nr8 + 1;
    if (bp.rx_valid && !pvp) nrp <= nrp + 1;
    if (b7.rx_valid && !pv7) nr7 <= nr7 + 1;
    if (b8.rx_valid) hi8 <= hi8 + 1;
  end
  task automatic drive(input int sel, input logic v);
    if (sel == 0) r8 = v;
    else if (sel == 1) rp = v;
    else r7 = v;
  endtask
  task automatic send(input int sel, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      drive(sel, f[i]);
      repeat (64) @(posedge clk);
    end
  endtask
  task automatic test_reset;
    int ticks;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (b8.tick !== 1'b0) $display("FAIL reset_tick: got %b exp 0", b8.tick); else pass_cnt++;
    total_cnt++; if (b8.rx_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", b8.rx_valid); else pass_cnt++;
    total_cnt++; if (b8.data_out !== 8'h00) $display("FAIL reset_data: got %h exp 00", b8.data_out); else pass_cnt++;
    total_cnt++; if ({b8.parity_err, b8.frame_err, b8.overrun} !== 3'b000)
      $display("FAIL reset_flags: got %b exp 000", {b8.parity_err, b8.frame_err, b8.overrun}); else pass_cnt++;
    reset = 1'b0;
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b8.tick) ticks++;
    end
    total_cnt++; if (ticks !== 10) $display("FAIL tick_rate: got %0d exp 10", ticks); else pass_cnt++;
    repeat (100) @(posedge clk);
  endtask
  task automatic test_8n1;
    int n0, h0;
    n0 = nr8; h0 = hi8;
    send(0, {1'b1, 8'h55, 1'b0}, 10);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (nr8 - n0 !== 1) $display("FAIL 8n1_count: got %0d exp 1", nr8 - n0); else pass_cnt++;
    total_cnt++; if (hi8 - h0 !== 1) $display("FAIL 8n1_pulse: got %0d exp 1", hi8 - h0); else pass_cnt++;
    total_cnt++; if (b8.data_out !== 8'h55) $display("FAIL 8n1_data: got %h exp 55", b8.data_out); else pass_cnt++;
    total_cnt++; if ({b8.parity_err, b8.frame_err, b8.overrun} !== 3'b000)
      $display("FAIL 8n1_flags: got %b exp 000", {b8.parity_err, b8.frame_err, b8.overrun}); else pass_cnt++;
  endtask
  task automatic test_parity;
    int n0;
    n0 = nrp;
    send(1, {1'b1, 1'b1, 8'hA3, 1'b0}, 11);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (nrp - n0 !== 1) $display("FAIL par_count: got %0d exp 1", nrp - n0); else pass_cnt++;
    total_cnt++; if (bp.data_out !== 8'hA3) $display("FAIL par_bad_data: got %h exp a3", bp.data_out); else pass_cnt++;
    total_cnt++; if (bp.parity_err !== 1'b1) $display("FAIL par_bad_err: got %b exp 1", bp.parity_err); else pass_cnt++;
    send(1, {1'b1, 1'b0, 8'hA3, 1'b0}, 11);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (nrp - n0 !== 2) $display("FAIL par_count2: got %0d exp 2", nrp - n0); else pass_cnt++;
    total_cnt++; if (bp.parity_err !== 1'b0) $display("FAIL par_good_err: got %b exp 0", bp.parity_err); else pass_cnt++;
    total_cnt++; if (bp.frame_err !== 1'b0) $display("FAIL par_good_ferr: got %b exp 0", bp.frame_err); else pass_cnt++;
  endtask
  task automatic test_break;
    int n0;
    n0 = nr8;
    send(0, {1'b0, 8'h3C, 1'b0}, 10);
    repeat (200) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (nr8 - n0 !== 1) $display("FAIL brk_count: got %0d exp 1", nr8 - n0); else pass_cnt++;
    total_cnt++; if (b8.frame_err !== 1'b1) $display("FAIL brk_ferr: got %b exp 1", b8.frame_err); else pass_cnt++;
    total_cnt++; if (b8.data_out !== 8'h3C) $display("FAIL brk_data: got %h exp 3c", b8.data_out); else pass_cnt++;
    drive(0, 1'b1);
    repeat (128) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (nr8 - n0 !== 1) $display("FAIL brk_no_second: got %0d exp 1", nr8 - n0); else pass_cnt++;
    send(0, {1'b1, 8'h81, 1'b0}, 10);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (nr8 - n0 !== 2) $display("FAIL brk_next_count: got %0d exp 2", nr8 - n0); else pass_cnt++;
    total_cnt++; if (b8.data_out !== 8'h81) $display("FAIL brk_next_data: got %h exp 81", b8.data_out); else pass_cnt++;
    total_cnt++; if (b8.frame_err !== 1'b0) $display("FAIL brk_next_ferr: got %b exp 0", b8.frame_err); else pass_cnt++;
  endtask
  task automatic test_glitch;
    int n0;
    n0 = nr8;
    drive(0, 1'b0);
    repeat (16) @(posedge clk);
    drive(0, 1'b1);
    repeat (128) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (nr8 - n0 !== 0) $display("FAIL glitch_count: got %0d exp 0", nr8 - n0); else pass_cnt++;
    send(0, {1'b1, 8'h96, 1'b0}, 10);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (nr8 - n0 !== 1) $display("FAIL glitch_after_count: got %0d exp 1", nr8 - n0); else pass_cnt++;
    total_cnt++; if (b8.data_out !== 8'h96) $display("FAIL glitch_after_data: got %h exp 96", b8.data_out); else pass_cnt++;
  endtask
  task automatic test_back_to_back;
    int n0;
    n0 = nr8;
    @(negedge clk);
    rdy8 = 1'b0;
    send(0, {1'b1, 8'h11, 1'b0}, 10);
    @(negedge clk);
    total_cnt++; if ({b8.rx_valid, b8.overrun} !== 2'b10)
      $display("FAIL ovr_first: got %b exp 10", {b8.rx_valid, b8.overrun}); else pass_cnt++;
    send(0, {1'b1, 8'h22, 1'b0}, 10);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (b8.data_out !== 8'h11) $display("FAIL ovr_data: got %h exp 11", b8.data_out); else pass_cnt++;
    total_cnt++; if ({b8.rx_valid, b8.overrun} !== 2'b11)
      $display("FAIL ovr_set: got %b exp 11", {b8.rx_valid, b8.overrun}); else pass_cnt++;
    total_cnt++; if (nr8 - n0 !== 1) $display("FAIL ovr_count: got %0d exp 1", nr8 - n0); else pass_cnt++;
    rdy8 = 1'b1;
    @(negedge clk);
    rdy8 = 1'b0;
    @(negedge clk);
    total_cnt++; if ({b8.rx_valid, b8.overrun} !== 2'b00)
      $display("FAIL ovr_clear: got %b exp 00", {b8.rx_valid, b8.overrun}); else pass_cnt++;
    total_cnt++; if (b8.data_out !== 8'h11) $display("FAIL ovr_hold_data: got %h exp 11", b8.data_out); else pass_cnt++;
    rdy8 = 1'b1;
  endtask
  task automatic test_reset_abort;
    int n0;
    n0 = nr7;
    send(2, {2'b11, 7'h5A, 1'b0}, 4);
    drive(2, 1'b1);
    repeat (32) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (nr7 - n0 !== 0) $display("FAIL abort_count: got %0d exp 0", nr7 - n0); else pass_cnt++;
    total_cnt++; if (b7.data_out !== 7'h00) $display("FAIL abort_data: got %h exp 00", b7.data_out); else pass_cnt++;
    send(2, {2'b11, 7'h21, 1'b0}, 10);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (nr7 - n0 !== 1) $display("FAIL 7n2_count: got %0d exp 1", nr7 - n0); else pass_cnt++;
    total_cnt++; if (b7.data_out !== 7'h21) $display("FAIL 7n2_data: got %h exp 21", b7.data_out); else pass_cnt++;
    total_cnt++; if ({b7.parity_err, b7.frame_err, b7.overrun} !== 3'b000)
      $display("FAIL 7n2_flags: got %b exp 000", {b7.parity_err, b7.frame_err, b7.overrun}); else pass_cnt++;
    send(2, {2'b10, 7'h33, 1'b0}, 10);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (b7.data_out !== 7'h33) $display("FAIL 7n2_stop2_data: got %h exp 33", b7.data_out); else pass_cnt++;
    total_cnt++; if (b7.frame_err !== 1'b1) $display("FAIL 7n2_stop2_ferr: got %b exp 1", b7.frame_err); else pass_cnt++;
  endtask
  initial begin
    test_reset;
    test_8n1;
    test_parity;
    test_break;
    test_glitch;
    test_back_to_back;
    test_reset_abort;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
